// File: rtl/multi_channel_graph_buffer.sv
// Double-buffered column-height cache: bursts N_CH*N_COLS samples from the char RAM into a
// shadow buffer, then swaps it into the visible buffer (optionally at end of frame).
module multi_channel_graph_buffer #(
   parameter int          N_CH        = 5,
   parameter int          N_COLS      = 20,
   parameter int          W           = 8,
   parameter int          AW          = 13,
   parameter logic [AW-1:0] BASE_ADDR = 13'h800,
   parameter int          CH_STRIDE   = 20,
   parameter int          READ_LAT    = 1,
   parameter int          SWAP_ON_EOF = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     trg,
   input  logic                     eof,
   input  logic [N_CH-1:0]          ch_mask,
   input  logic [W-1:0]             mem_rdata,
   output logic [AW-1:0]            mem_addr,
   output logic [N_CH*N_COLS*W-1:0] out,
   output logic                     busy,
   output logic                     frame_valid,
   output logic [7:0]               upd_cnt
);

   localparam int TOTAL = N_CH * N_COLS;
   localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int LW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int DW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StFetch   = 3'd1;
   localparam logic [2:0] StDrain   = 3'd2;
   localparam logic [2:0] StWaitEof = 3'd3;
   localparam logic [2:0] StSwap    = 3'd4;

   logic [2:0]              state;
   logic [IW-1:0]           idx;
   logic [CW-1:0]           ch;
   logic [LW-1:0]           col;
   logic [AW-1:0]           ch_base;
   logic [DW-1:0]           drain_cnt;
   logic                    pending;
   logic [N_CH*N_COLS*W-1:0] shadow;

   // Each issued address carries its entry index and mask bit down to the capture point.
   logic                    tag_vld [READ_LAT];
   logic [IW-1:0]           tag_idx [READ_LAT];
   logic                    tag_msk [READ_LAT];

   assign busy = (state != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         idx         <= '0;
         ch          <= '0;
         col         <= '0;
         ch_base     <= BASE_ADDR;
         mem_addr    <= BASE_ADDR;
         drain_cnt   <= '0;
         pending     <= 1'b0;
         shadow      <= '0;
         out         <= '0;
         frame_valid <= 1'b0;
         upd_cnt     <= 8'd0;
         for (int s = 0; s < READ_LAT; s++) begin
            tag_vld[s] <= 1'b0;
            tag_idx[s] <= '0;
            tag_msk[s] <= 1'b0;
         end
      end else begin
         tag_vld[0] <= (state == StFetch) && en;
         tag_idx[0] <= idx;
         tag_msk[0] <= ch_mask[ch];
         for (int s = 1; s < READ_LAT; s++) begin
            tag_vld[s] <= tag_vld[s-1] && en;
            tag_idx[s] <= tag_idx[s-1];
            tag_msk[s] <= tag_msk[s-1];
         end

         if (tag_vld[READ_LAT-1]) begin
            shadow[tag_idx[READ_LAT-1]*W +: W] <= tag_msk[READ_LAT-1] ? mem_rdata : '0;
         end

         if (state == StIdle) begin
            if (trg && en) begin
               state    <= StFetch;
               idx      <= '0;
               ch       <= '0;
               col      <= '0;
               ch_base  <= BASE_ADDR;
               mem_addr <= BASE_ADDR;
            end
         end else if (!en) begin
            state   <= StIdle;
            pending <= 1'b0;
         end else begin
            if (trg) pending <= 1'b1;
            case (state)
               StFetch: begin
                  if (idx == IW'(TOTAL - 1)) begin
                     state     <= StDrain;
                     drain_cnt <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                     if (col == LW'(N_COLS - 1)) begin
                        col      <= '0;
                        ch       <= ch + 1'b1;
                        ch_base  <= ch_base + AW'(CH_STRIDE);
                        mem_addr <= ch_base + AW'(CH_STRIDE);
                     end else begin
                        col      <= col + 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                     end
                  end
               end
               StDrain: begin
                  if (drain_cnt == DW'(READ_LAT - 1)) begin
                     state <= (SWAP_ON_EOF != 0) ? StWaitEof : StSwap;
                  end else begin
                     drain_cnt <= drain_cnt + 1'b1;
                  end
               end
               StWaitEof: begin
                  if (eof) state <= StSwap;
               end
               StSwap: begin
                  out         <= shadow;
                  frame_valid <= 1'b1;
                  upd_cnt     <= upd_cnt + 8'd1;
                  pending     <= 1'b0;
                  // A trigger landing in the swap cycle itself also restarts the fetch.
                  if (pending || trg) begin
                     state    <= StFetch;
                     idx      <= '0;
                     ch       <= '0;
                     col      <= '0;
                     ch_base  <= BASE_ADDR;
                     mem_addr <= BASE_ADDR;
                  end else begin
                     state <= StIdle;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule
